// File: rtl/synch_fifo_param.sv
// rtl/synch_fifo_param.sv - parametrised single-clock FIFO with count, threshold flags and sticky errors
//
// Purpose: same-clock-domain buffering between a producer and a consumer.
// Optional build macro: SYNCH_FIFO_FWFT_EN selects first-word-fall-through reads
// (the head word is shown on data_out while the FIFO is not empty). When the macro
// is undefined, a read returns data one cycle after rd_en is sampled.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   synchronous active-low reset
//   wr_en        in   write request
//   data_in      in   [DATA_WIDTH-1:0] write data
//   rd_en        in   read request (pop in FWFT mode)
//   clr_err      in   clears overflow/underflow (a new error in the same cycle wins)
//   data_out     out  [DATA_WIDTH-1:0] read data
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  [ADDR_WIDTH:0] occupancy, 0..DEPTH
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty

module synch_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode only the registered count, so they never depend on wr_en/rd_en
  // and they move on the same edge as count.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance uses the pre-edge flags: a read cannot rescue a write at full,
  // and a write cannot rescue a read at empty.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Storage is not reset; a write coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // hold_q captures the word being popped. In standard mode it is the read data;
  // in FWFT mode it is what data_out keeps showing once the FIFO runs empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (rd_acc) begin
      hold_q <= mem[rd_ptr];
    end
  end

`ifdef SYNCH_FIFO_FWFT_EN
  assign data_out = empty ? hold_q : mem[rd_ptr];
`else
  assign data_out = hold_q;
`endif

  // Sticky error flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_synch_fifo_param.sv
// tb/tb_synch_fifo_param.sv - directed self-checking bench for synch_fifo_param

module tb_synch_fifo_param;

`ifdef SYNCH_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  synch_fifo_param #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int q [13] = '{0, 1, 2, 3, 4, 10, 11, 12, 13, 14, 15, 16, 17};

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    step;
    step;
    rst_n = 1'b1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_dout", 32'(data_out), 0);

    // Write 0..9 then idle
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      step;
    end
    wr_en = 1'b0;
    step;
    chk("t1_count", 32'(count), 10);
    chk("t1_empty", 32'(empty), 0);
    chk("t1_af", 32'(almost_full), 0);
    chk("t1_ae", 32'(almost_empty), 0);
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      step;
      chk("t1_rd_data", 32'(data_out), FWFT ? 32'(i + 1) : 32'(i));
    end
    rd_en = 1'b0;
    chk("t1_count5", 32'(count), 5);
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      step;
    end
    rd_en = 1'b0;
    chk("t1_drained", 32'(empty), 1);

    // Fill to full across the pointer wrap
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1; data_in = 8'(16 + k);
      step;
      chk("t2_count", 32'(count), 32'(k + 1));
      chk("t2_af", 32'(almost_full), (k + 1 >= 14) ? 1 : 0);
      chk("t2_full", 32'(full), (k == 15) ? 1 : 0);
    end
    data_in = 8'hEE;
    step;
    wr_en = 1'b0;
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_ovf_count", 32'(count), 16);
    chk("t2_ovf_full", 32'(full), 1);
    for (int k = 0; k < 16; k++) begin
      rd_en = 1'b1;
      step;
      if (FWFT) chk("t2_rd_data", 32'(data_out), (k < 15) ? 32'(17 + k) : 32'h1F);
      else      chk("t2_rd_data", 32'(data_out), 32'(16 + k));
    end
    rd_en = 1'b0;
    chk("t2_count0", 32'(count), 0);
    chk("t2_empty", 32'(empty), 1);

    // Underflow and clear
    rd_en = 1'b1;
    step;
    rd_en = 1'b0;
    chk("t3_unf", 32'(underflow), 1);
    chk("t3_dout_hold", 32'(data_out), 32'h1F);
    chk("t3_count", 32'(count), 0);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("t3_unf_clr", 32'(underflow), 0);
    chk("t3_ovf_clr", 32'(overflow), 0);
    clr_err = 1'b1; rd_en = 1'b1;
    step;
    clr_err = 1'b0; rd_en = 1'b0;
    chk("t3_set_wins", 32'(underflow), 1);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("t3_unf_clr2", 32'(underflow), 0);

    // Simultaneous write and read at count 5
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      step;
    end
    wr_en = 1'b0;
    chk("t4_count5", 32'(count), 5);
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'(10 + k);
      step;
      chk("t4_count", 32'(count), 5);
      chk("t4_rd_data", 32'(data_out), FWFT ? 32'(q[k + 1]) : 32'(q[k]));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int k = 0; k < 11; k++) begin
      wr_en = 1'b1; data_in = 8'(32 + k);
      step;
    end
    wr_en = 1'b0;
    chk("t4_full", 32'(full), 1);
    chk("t4_full_count", 32'(count), 16);
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h99;
    step;
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t4_full_ovf", 32'(overflow), 1);
    chk("t4_full_count15", 32'(count), 15);
    chk("t4_full_flag", 32'(full), 0);
    chk("t4_full_rd", 32'(data_out), FWFT ? 32'd14 : 32'd13);

    // Reset mid-stream at count 9
    for (int k = 0; k < 6; k++) begin
      rd_en = 1'b1;
      step;
    end
    rd_en = 1'b0;
    chk("t5_count9", 32'(count), 9);
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
    step;
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_ae", 32'(almost_empty), 1);
    chk("t5_dout", 32'(data_out), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_unf", 32'(underflow), 0);
    wr_en = 1'b1; data_in = 8'hA5;
    step;
    wr_en = 1'b0;
    chk("t5_wr_count", 32'(count), 1);
    chk("t5_wr_dout", 32'(data_out), FWFT ? 32'hA5 : 32'h00);
    rd_en = 1'b1;
    step;
    rd_en = 1'b0;
    chk("t5_rd_dout", 32'(data_out), 32'hA5);
    chk("t5_rd_empty", 32'(empty), 1);

    // Single word into an empty FIFO: visible without rd_en only in FWFT mode
    wr_en = 1'b1; data_in = 8'h33;
    step;
    wr_en = 1'b0;
    chk("t6_head", 32'(data_out), FWFT ? 32'h33 : 32'hA5);
    rd_en = 1'b1;
    step;
    rd_en = 1'b0;
    chk("t6_pop_empty", 32'(empty), 1);
    chk("t6_pop_dout", 32'(data_out), 32'h33);
    step;
    chk("t6_hold_dout", 32'(data_out), 32'h33);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
